// File: rtl/mm_seq_ctrl.sv
// Matrix-multiply sequencer: walks load, MAC and write-back phases over N_COLS
// columns of MAC_LEN MACs each, with ALU stall, A-matrix reuse and abort.
module mm_seq_ctrl #(
  parameter int N_COLS  = 4,
  parameter int MAC_LEN = 8,
  localparam int CW = $clog2(N_COLS),
  localparam int MW = $clog2(MAC_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_in,
  input  logic          keep_a,
  input  logic          abort,
  input  logic          xload_done,
  input  logic          aload_done,
  input  logic          alu_stall,
  output logic          input_load_en,
  output logic          a_load_en,
  output logic          alu_en,
  output logic          acc_clr,
  output logic [MW-1:0] mac_idx,
  output logic [CW-1:0] col_idx,
  output logic          res_we,
  output logic          busy,
  output logic          finish
);

  localparam logic [MW-1:0] LAST_MAC = MW'(MAC_LEN - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(N_COLS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MAC,
    S_WB,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic [MW-1:0] r_macIdx;
  logic [MW-1:0] w_nextMac;
  logic [CW-1:0] r_colIdx;
  logic [CW-1:0] w_nextCol;
  logic          r_aValid;
  logic          w_nextAValid;
  logic          r_keepQ;
  logic          w_nextKeep;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_macIdx <= '0;
      r_colIdx <= '0;
      r_aValid <= 1'b0;
      r_keepQ  <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_macIdx <= w_nextMac;
      r_colIdx <= w_nextCol;
      r_aValid <= w_nextAValid;
      r_keepQ  <= w_nextKeep;
    end
  end

  // A stalled MAC cycle issues nothing and leaves both the index and the state frozen.
  always_comb begin
    w_nextState   = r_state;
    w_nextMac     = r_macIdx;
    w_nextCol     = r_colIdx;
    w_nextAValid  = r_aValid;
    w_nextKeep    = r_keepQ;
    input_load_en = 1'b0;
    a_load_en     = 1'b0;
    alu_en        = 1'b0;
    acc_clr       = 1'b0;
    res_we        = 1'b0;
    finish        = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_nextMac = '0;
        w_nextCol = '0;
        if (start_in) begin
          w_nextState = S_LOAD;
          w_nextKeep  = keep_a & r_aValid;
        end
      end
      S_LOAD: begin
        input_load_en = 1'b1;
        a_load_en     = ~r_keepQ;
        if (xload_done && (aload_done || r_keepQ)) begin
          w_nextState  = S_MAC;
          w_nextAValid = 1'b1;
        end
      end
      S_MAC: begin
        alu_en  = ~alu_stall;
        acc_clr = ~alu_stall && (r_macIdx == '0);
        if (!alu_stall) begin
          if (r_macIdx == LAST_MAC) begin
            w_nextMac   = '0;
            w_nextState = S_WB;
          end else begin
            w_nextMac = r_macIdx + 1'b1;
          end
        end
      end
      S_WB: begin
        res_we = 1'b1;
        if (r_colIdx == LAST_COL) begin
          w_nextCol   = '0;
          w_nextState = S_DONE;
        end else begin
          w_nextCol   = r_colIdx + 1'b1;
          w_nextState = S_MAC;
        end
      end
      S_DONE: begin
        finish      = 1'b1;
        w_nextState = S_IDLE;
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase

    // Abort discards the job, including any result or completion pulse this cycle.
    if (abort) begin
      w_nextState  = S_IDLE;
      w_nextMac    = '0;
      w_nextCol    = '0;
      w_nextAValid = 1'b0;
      res_we       = 1'b0;
      finish       = 1'b0;
    end
  end

  assign mac_idx = r_macIdx;
  assign col_idx = r_colIdx;
  assign busy    = (r_state != S_IDLE);

  assert property (@(posedge clk) disable iff (rst) (r_macIdx <= LAST_MAC));
  assert property (@(posedge clk) disable iff (rst) (r_colIdx <= LAST_COL));
  assert property (@(posedge clk) disable iff (rst) (finish |=> !finish));

endmodule
